// File: rtl/fsab_cpu_arbiter_pkg.sv
// fsab_cpu_arbiter_pkg: FSAB request field widths, beat layout and arbiter types
package fsab_cpu_arbiter_pkg;
    localparam int FSAB_MODE_W          = 1;
    localparam int FSAB_DID_W           = 4;
    localparam int FSAB_SUBDID_W        = 4;
    localparam int FSAB_ADDR_W          = 31;
    localparam int FSAB_LEN_W           = 4;
    localparam int FSAB_DATA_W          = 64;
    localparam int FSAB_MASK_W          = 8;
    localparam int FSAB_INITIAL_CREDITS = 4;
    localparam int FSAB_BEAT_W          = FSAB_MODE_W + FSAB_DID_W + FSAB_SUBDID_W + FSAB_ADDR_W
                                        + FSAB_LEN_W + FSAB_DATA_W + FSAB_MASK_W;

    localparam logic [FSAB_MODE_W-1:0] FSAB_READ  = 1'b0;
    localparam logic [FSAB_MODE_W-1:0] FSAB_WRITE = 1'b1;

    typedef struct packed {
        logic [FSAB_MODE_W-1:0]   mode;
        logic [FSAB_DID_W-1:0]    did;
        logic [FSAB_SUBDID_W-1:0] subdid;
        logic [FSAB_ADDR_W-1:0]   addr;
        logic [FSAB_LEN_W-1:0]    len;
        logic [FSAB_DATA_W-1:0]   data;
        logic [FSAB_MASK_W-1:0]   mask;
    } fsab_beat_t;

    typedef enum logic {ST_IDLE, ST_BURST} arb_state_t;

    // A header beat opens a locked burst only when more beats follow it.
    function automatic logic opens_burst(input fsab_beat_t b);
        return b.mode == FSAB_WRITE && b.len > FSAB_LEN_W'(1);
    endfunction
endpackage

// File: rtl/fsab_skid_fifo.sv
// fsab_skid_fifo: small per-client skid FIFO; caller never pushes while full
module fsab_skid_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    // Storage write, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fsab_cpu_arbiter.sv
// fsab_cpu_arbiter: round-robin, burst-locking, credit-tracked merge of cache clients onto one FSAB port
module fsab_cpu_arbiter
    import fsab_cpu_arbiter_pkg::*;
#(
    parameter int NCLIENTS   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int UP_CREDITS = FSAB_INITIAL_CREDITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NCLIENTS-1:0]               cli_fsabo_valid,
    input  logic [NCLIENTS*FSAB_MODE_W-1:0]   cli_fsabo_mode,
    input  logic [NCLIENTS*FSAB_DID_W-1:0]    cli_fsabo_did,
    input  logic [NCLIENTS*FSAB_SUBDID_W-1:0] cli_fsabo_subdid,
    input  logic [NCLIENTS*FSAB_ADDR_W-1:0]   cli_fsabo_addr,
    input  logic [NCLIENTS*FSAB_LEN_W-1:0]    cli_fsabo_len,
    input  logic [NCLIENTS*FSAB_DATA_W-1:0]   cli_fsabo_data,
    input  logic [NCLIENTS*FSAB_MASK_W-1:0]   cli_fsabo_mask,
    output logic [NCLIENTS-1:0]               cli_fsabo_credit,
    output logic                              fsabo_valid,
    output logic [FSAB_MODE_W-1:0]            fsabo_mode,
    output logic [FSAB_DID_W-1:0]             fsabo_did,
    output logic [FSAB_SUBDID_W-1:0]          fsabo_subdid,
    output logic [FSAB_ADDR_W-1:0]            fsabo_addr,
    output logic [FSAB_LEN_W-1:0]             fsabo_len,
    output logic [FSAB_DATA_W-1:0]            fsabo_data,
    output logic [FSAB_MASK_W-1:0]            fsabo_mask,
    input  logic                              fsabo_credit,
    output logic [1:0]                        cur_owner
);
    localparam int CW = $clog2(UP_CREDITS + 1);

    fsab_beat_t          head [4];
    logic [3:0]          empty;
    logic [NCLIENTS-1:0] pop;
    fsab_beat_t          hb;
    logic                fwd;
    logic [1:0]          sel;

    arb_state_t          state, state_n;
    logic [1:0]          lock, lock_n, last_grant, last_n;
    logic [FSAB_LEN_W-1:0] beats_left, left_n;
    logic [CW-1:0]       up_credits, up_n;
    logic [CW:0]         up_sum;

    // Unused slots up to four are tied empty so selection can index with 2 bits
    for (genvar i = 0; i < 4; i++) begin : g_cli
        if (i < NCLIENTS) begin : g_fifo
            fsab_beat_t din;
            logic       full;
            assign din = {cli_fsabo_mode[i*FSAB_MODE_W +: FSAB_MODE_W],
                          cli_fsabo_did[i*FSAB_DID_W +: FSAB_DID_W],
                          cli_fsabo_subdid[i*FSAB_SUBDID_W +: FSAB_SUBDID_W],
                          cli_fsabo_addr[i*FSAB_ADDR_W +: FSAB_ADDR_W],
                          cli_fsabo_len[i*FSAB_LEN_W +: FSAB_LEN_W],
                          cli_fsabo_data[i*FSAB_DATA_W +: FSAB_DATA_W],
                          cli_fsabo_mask[i*FSAB_MASK_W +: FSAB_MASK_W]};
            fsab_skid_fifo #(.W(FSAB_BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (cli_fsabo_valid[i] && !full),
                .din   (din),
                .pop   (pop[i]),
                .full  (full),
                .empty (empty[i]),
                .head  (head[i])
            );
        end else begin : g_tie
            assign empty[i] = 1'b1;
            assign head[i]  = '0;
        end
    end

    assign hb     = head[sel];
    assign up_sum = {1'b0, up_credits} + (CW+1)'(fsabo_credit) - (CW+1)'(fwd);
    assign up_n   = up_sum > (CW+1)'(UP_CREDITS) ? CW'(UP_CREDITS) : up_sum[CW-1:0];

    // Arbiter state, burst lock and upstream credit count
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lock       <= '0;
            beats_left <= '0;
            last_grant <= 2'(NCLIENTS - 1);
            up_credits <= CW'(UP_CREDITS);
        end else begin
            state      <= state_n;
            lock       <= lock_n;
            beats_left <= left_n;
            last_grant <= last_n;
            up_credits <= up_n;
        end
    end

    // Next state: a multi-beat write header locks the port until its last beat leaves
    always_comb begin
        state_n = state;
        lock_n  = lock;
        left_n  = beats_left;
        last_n  = last_grant;
        if (fwd) begin
            last_n = sel;
            if (state == ST_IDLE && opens_burst(hb)) begin
                state_n = ST_BURST;
                lock_n  = sel;
                left_n  = hb.len - 1'b1;
            end else if (state == ST_BURST) begin
                left_n  = beats_left - 1'b1;
                state_n = beats_left == FSAB_LEN_W'(1) ? ST_IDLE : ST_BURST;
            end
        end
    end

    // Winner selection: locked client in a burst, else first ready client after last_grant
    always_comb begin
        fwd = 1'b0;
        sel = lock;
        if (state == ST_BURST) begin
            fwd = !empty[lock] && up_credits != '0;
        end else begin
            for (int k = NCLIENTS; k >= 1; k--) begin
                if (!empty[2'((int'(last_grant) + k) % NCLIENTS)] && up_credits != '0) begin
                    fwd = 1'b1;
                    sel = 2'((int'(last_grant) + k) % NCLIENTS);
                end
            end
        end
        pop = fwd ? NCLIENTS'(1) << sel : '0;
    end

    // Registered upstream beat and client credit pulse; fields hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            fsabo_valid      <= 1'b0;
            fsabo_mode       <= '0;
            fsabo_did        <= '0;
            fsabo_subdid     <= '0;
            fsabo_addr       <= '0;
            fsabo_len        <= '0;
            fsabo_data       <= '0;
            fsabo_mask       <= '0;
            cli_fsabo_credit <= '0;
            cur_owner        <= '0;
        end else begin
            fsabo_valid      <= fwd;
            cli_fsabo_credit <= pop;
            if (fwd) begin
                fsabo_mode   <= hb.mode;
                fsabo_did    <= hb.did;
                fsabo_subdid <= hb.subdid;
                fsabo_addr   <= hb.addr;
                fsabo_len    <= hb.len;
                fsabo_data   <= hb.data;
                fsabo_mask   <= hb.mask;
                cur_owner    <= sel;
            end
        end
    end
endmodule

// File: tb/tb_fsab_cpu_arbiter.sv
// tb_fsab_cpu_arbiter: directed checks of arbitration, burst lock, credits and reset
module tb_fsab_cpu_arbiter;
    import fsab_cpu_arbiter_pkg::*;

    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]               c_valid  = '0;
    logic [NC*FSAB_MODE_W-1:0]   c_mode   = '0;
    logic [NC*FSAB_DID_W-1:0]    c_did    = '0;
    logic [NC*FSAB_SUBDID_W-1:0] c_subdid = '0;
    logic [NC*FSAB_ADDR_W-1:0]   c_addr   = '0;
    logic [NC*FSAB_LEN_W-1:0]    c_len    = '0;
    logic [NC*FSAB_DATA_W-1:0]   c_data   = '0;
    logic [NC*FSAB_MASK_W-1:0]   c_mask   = '0;
    logic [NC-1:0]               cli_fsabo_credit;
    logic                        fsabo_valid;
    logic [FSAB_MODE_W-1:0]      fsabo_mode;
    logic [FSAB_DID_W-1:0]       fsabo_did;
    logic [FSAB_SUBDID_W-1:0]    fsabo_subdid;
    logic [FSAB_ADDR_W-1:0]      fsabo_addr;
    logic [FSAB_LEN_W-1:0]       fsabo_len;
    logic [FSAB_DATA_W-1:0]      fsabo_data;
    logic [FSAB_MASK_W-1:0]      fsabo_mask;
    logic [1:0]                  cur_owner;
    logic                        ret_auto = 1'b0;
    logic                        ret_man  = 1'b0;
    logic                        fsabo_credit;

    assign fsabo_credit = ret_man | (ret_auto & fsabo_valid);

    fsab_cpu_arbiter #(.NCLIENTS(NC), .FIFO_DEPTH(4), .UP_CREDITS(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .cli_fsabo_valid  (c_valid),
        .cli_fsabo_mode   (c_mode),
        .cli_fsabo_did    (c_did),
        .cli_fsabo_subdid (c_subdid),
        .cli_fsabo_addr   (c_addr),
        .cli_fsabo_len    (c_len),
        .cli_fsabo_data   (c_data),
        .cli_fsabo_mask   (c_mask),
        .cli_fsabo_credit (cli_fsabo_credit),
        .fsabo_valid      (fsabo_valid),
        .fsabo_mode       (fsabo_mode),
        .fsabo_did        (fsabo_did),
        .fsabo_subdid     (fsabo_subdid),
        .fsabo_addr       (fsabo_addr),
        .fsabo_len        (fsabo_len),
        .fsabo_data       (fsabo_data),
        .fsabo_mask       (fsabo_mask),
        .fsabo_credit     (fsabo_credit),
        .cur_owner        (cur_owner)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input int c, input logic w, input logic [30:0] a, input logic [3:0] l,
                        input logic [63:0] d);
        c_valid[c]                         = 1'b1;
        c_mode[c]                          = w;
        c_did[c*FSAB_DID_W +: FSAB_DID_W]  = 4'(c + 1);
        c_subdid[c*FSAB_SUBDID_W +: FSAB_SUBDID_W] = 4'h5;
        c_addr[c*FSAB_ADDR_W +: FSAB_ADDR_W] = a;
        c_len[c*FSAB_LEN_W +: FSAB_LEN_W]  = l;
        c_data[c*FSAB_DATA_W +: FSAB_DATA_W] = d;
        c_mask[c*FSAB_MASK_W +: FSAB_MASK_W] = 8'hFF;
    endtask

    task automatic idle_cli();
        c_valid = '0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid", 64'(fsabo_valid), 64'd0);
        chk("rst_addr", 64'(fsabo_addr), 64'd0);
        chk("rst_data", fsabo_data, 64'd0);
        chk("rst_credit", 64'(cli_fsabo_credit), 64'd0);
        chk("rst_owner", 64'(cur_owner), 64'd0);
        chk("rst_up", 64'(dut.up_credits), 64'd2);

        // round-robin: both clients ready together, client 0 first after reset
        ret_auto = 1'b1;
        send(0, FSAB_READ, 31'h2000, 4'd1, 64'h0);
        send(1, FSAB_READ, 31'h3000, 4'd1, 64'h0);
        step();
        idle_cli();
        chk("rr_latency", 64'(fsabo_valid), 64'd0);
        step();
        chk("rr0_valid", 64'(fsabo_valid), 64'd1);
        chk("rr0_addr", 64'(fsabo_addr), 64'h2000);
        chk("rr0_owner", 64'(cur_owner), 64'd0);
        chk("rr0_credit", 64'(cli_fsabo_credit), 64'b01);
        step();
        chk("rr1_addr", 64'(fsabo_addr), 64'h3000);
        chk("rr1_owner", 64'(cur_owner), 64'd1);
        chk("rr1_credit", 64'(cli_fsabo_credit), 64'b10);
        step();
        chk("rr_done_valid", 64'(fsabo_valid), 64'd0);
        chk("rr_up", 64'(dut.up_credits), 64'd2);
        ret_auto = 1'b0;

        // single read
        send(0, FSAB_READ, 31'h1000, 4'd8, 64'h0);
        step();
        idle_cli();
        chk("rd_latency", 64'(fsabo_valid), 64'd0);
        step();
        chk("rd_valid", 64'(fsabo_valid), 64'd1);
        chk("rd_addr", 64'(fsabo_addr), 64'h1000);
        chk("rd_len", 64'(fsabo_len), 64'd8);
        chk("rd_mode", 64'(fsabo_mode), 64'(FSAB_READ));
        chk("rd_did", 64'(fsabo_did), 64'd1);
        chk("rd_credit", 64'(cli_fsabo_credit), 64'b01);
        chk("rd_up", 64'(dut.up_credits), 64'd1);
        step();
        chk("rd_after_valid", 64'(fsabo_valid), 64'd0);
        chk("rd_after_credit", 64'(cli_fsabo_credit), 64'd0);
        chk("rd_hold_addr", 64'(fsabo_addr), 64'h1000);
        ret_man = 1'b1;
        step();
        ret_man = 1'b0;
        chk("ret_up", 64'(dut.up_credits), 64'd2);
        ret_man = 1'b1;
        step();
        ret_man = 1'b0;
        chk("sat_up", 64'(dut.up_credits), 64'd2);

        // credit return in the same cycle as a forward
        send(0, FSAB_READ, 31'h1100, 4'd1, 64'h0);
        step();
        idle_cli();
        ret_man = 1'b1;
        step();
        ret_man = 1'b0;
        chk("cf_valid", 64'(fsabo_valid), 64'd1);
        chk("cf_addr", 64'(fsabo_addr), 64'h1100);
        chk("cf_up", 64'(dut.up_credits), 64'd2);

        // burst lock: client 1 writes 4 beats, client 0 reads during beat 2
        ret_auto = 1'b1;
        send(1, FSAB_WRITE, 31'h4000, 4'd4, 64'hA0);
        step();
        send(1, FSAB_WRITE, 31'h4000, 4'd4, 64'hA1);
        send(0, FSAB_READ, 31'h5000, 4'd1, 64'h0);
        step();
        idle_cli();
        send(1, FSAB_WRITE, 31'h4000, 4'd4, 64'hA2);
        chk("b0_valid", 64'(fsabo_valid), 64'd1);
        chk("b0_data", fsabo_data, 64'hA0);
        chk("b0_mode", 64'(fsabo_mode), 64'(FSAB_WRITE));
        chk("b0_owner", 64'(cur_owner), 64'd1);
        chk("b0_credit", 64'(cli_fsabo_credit), 64'b10);
        step();
        send(1, FSAB_WRITE, 31'h4000, 4'd4, 64'hA3);
        chk("b1_data", fsabo_data, 64'hA1);
        chk("b1_owner", 64'(cur_owner), 64'd1);
        step();
        idle_cli();
        chk("b2_data", fsabo_data, 64'hA2);
        chk("b2_owner", 64'(cur_owner), 64'd1);
        step();
        chk("b3_valid", 64'(fsabo_valid), 64'd1);
        chk("b3_data", fsabo_data, 64'hA3);
        chk("b3_owner", 64'(cur_owner), 64'd1);
        step();
        chk("b_rd_valid", 64'(fsabo_valid), 64'd1);
        chk("b_rd_addr", 64'(fsabo_addr), 64'h5000);
        chk("b_rd_owner", 64'(cur_owner), 64'd0);
        step();
        chk("b_end_valid", 64'(fsabo_valid), 64'd0);
        chk("b_end_up", 64'(dut.up_credits), 64'd2);
        ret_auto = 1'b0;

        // credit stall: two credits, three reads
        send(0, FSAB_READ, 31'h6000, 4'd1, 64'h0);
        step();
        send(0, FSAB_READ, 31'h6010, 4'd1, 64'h0);
        step();
        send(0, FSAB_READ, 31'h6020, 4'd1, 64'h0);
        chk("st0_addr", 64'(fsabo_addr), 64'h6000);
        step();
        idle_cli();
        chk("st1_valid", 64'(fsabo_valid), 64'd1);
        chk("st1_addr", 64'(fsabo_addr), 64'h6010);
        step();
        chk("st_hold_valid", 64'(fsabo_valid), 64'd0);
        step();
        chk("st_hold2_valid", 64'(fsabo_valid), 64'd0);
        chk("st_up0", 64'(dut.up_credits), 64'd0);
        ret_man = 1'b1;
        step();
        ret_man = 1'b0;
        chk("st_ret_valid", 64'(fsabo_valid), 64'd0);
        chk("st_ret_up", 64'(dut.up_credits), 64'd1);
        step();
        chk("st2_valid", 64'(fsabo_valid), 64'd1);
        chk("st2_addr", 64'(fsabo_addr), 64'h6020);
        chk("st2_up", 64'(dut.up_credits), 64'd0);
        ret_man = 1'b1;
        step();
        step();
        ret_man = 1'b0;
        chk("st_restore_up", 64'(dut.up_credits), 64'd2);

        // reset in the middle of a len-8 write, with a read queued behind it
        ret_auto = 1'b1;
        send(1, FSAB_WRITE, 31'h9000, 4'd8, 64'hB0);
        step();
        send(1, FSAB_WRITE, 31'h9000, 4'd8, 64'hB1);
        send(0, FSAB_READ, 31'h7777, 4'd1, 64'h0);
        step();
        idle_cli();
        send(1, FSAB_WRITE, 31'h9000, 4'd8, 64'hB2);
        chk("mr0_data", fsabo_data, 64'hB0);
        step();
        send(1, FSAB_WRITE, 31'h9000, 4'd8, 64'hB3);
        chk("mr1_data", fsabo_data, 64'hB1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_cli();
        chk("mr_valid", 64'(fsabo_valid), 64'd0);
        chk("mr_addr", 64'(fsabo_addr), 64'd0);
        chk("mr_data", fsabo_data, 64'd0);
        chk("mr_len", 64'(fsabo_len), 64'd0);
        chk("mr_credit", 64'(cli_fsabo_credit), 64'd0);
        chk("mr_owner", 64'(cur_owner), 64'd0);
        chk("mr_up", 64'(dut.up_credits), 64'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_empty_valid", 64'(fsabo_valid), 64'd0);
        end
        send(0, FSAB_READ, 31'h8000, 4'd1, 64'h0);
        step();
        idle_cli();
        step();
        chk("mr_rd_valid", 64'(fsabo_valid), 64'd1);
        chk("mr_rd_addr", 64'(fsabo_addr), 64'h8000);
        chk("mr_rd_owner", 64'(cur_owner), 64'd0);
        chk("mr_rd_up", 64'(dut.up_credits), 64'd1);
        ret_auto = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fsab_cpu_arbiter.md
# fsab_cpu_arbiter

Shares the CPU's single outbound FSAB request port between several cache clients, such as the instruction cache and a write-back data cache. Each client gets a credit-based skid FIFO. The block runs round-robin arbitration with burst locking, so multi-beat writes stay contiguous. It tracks upstream FSAB credits and forwards one registered beat per cycle to the memory-side arbiter.

## Interface
Parameters:
- NCLIENTS, 2, number of requesters (2..4); client 0 is the instruction cache.
- FIFO_DEPTH, 4, per-client skid FIFO depth (power of two); also the number of credits each client owns after reset.
- UP_CREDITS, FSAB_INITIAL_CREDITS, upstream credits owned after reset.

Ports (per-client buses are flattened, with client i in slice i):
- clk  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cli_fsabo_valid  in  NCLIENTS  beat strobe per client.
- cli_fsabo_mode/did/subdid/addr/len/data/mask  in  NCLIENTS×field width  per-client FSAB request fields.
- cli_fsabo_credit  out  NCLIENTS  one-cycle credit return per client.
- fsabo_valid/mode/did/subdid/addr/len/data/mask  out  FSAB widths  registered upstream request.
- fsabo_credit  in  1  upstream credit return.
- cur_owner  out  2  client index of the last granted beat (debug).

## Operation
- **Client side:**
  - A client drives a beat only while its own credit count is nonzero.
  - Each beat is pushed into FIFO i as {mode,did,subdid,addr,len,data,mask}.
  - Pushing into a full FIFO is a protocol violation: the beat is dropped and `$display("FSABARB: overflow client %d")` fires.
- **Burst length:**
  - A read is 1 beat.
  - A write is len beats (header beat followed by len−1 data beats).
  - A write with len == 0 is treated as 1 beat.
- **Arbiter states:**
  - IDLE: no grant held.
  - BURST: locked to one client with beats_left > 0.
- **IDLE behaviour:**
  - Eligible clients are those with a non-empty FIFO, but only when up_credits != 0.
  - The winner is chosen round-robin, starting from the client after last_grant.
  - The head beat is forwarded.
  - If it is a write with len > 1, load beats_left = len−1 and enter BURST.
- **BURST behaviour:**
  - Only the locked client is serviced.
  - Each forwarded beat decrements beats_left; at 0, return to IDLE.
  - If the locked FIFO is empty or up_credits == 0, output nothing that cycle and keep the lock.
- **Forwarding a beat:**
  - Pop the FIFO and pulse cli_fsabo_credit[i] in the same cycle.
  - Load the output registers and decrement up_credits.
- **Upstream credit counter:**
  - up_credits_next = up_credits + fsabo_credit − forwarded.
  - A simultaneous credit return and forward leaves the count unchanged.
  - Never exceeds UP_CREDITS; exceeding it is an error (`$display`), saturate.
- **Non-forwarding cycles:** fsabo_valid = 0 and the other outputs hold their previous values.
- **Reset mid-operation:**
  - FIFOs are emptied, the lock is cleared and last_grant = NCLIENTS−1 (so client 0 wins first).
  - up_credits = UP_CREDITS.
  - In-flight client beats in the reset cycle are discarded.

## Timing
- Push to FIFO at edge N. Beat is visible on fsabo_* at edge N+1 at earliest, i.e. 1-cycle registered latency with an empty FIFO and an idle arbiter.
- Credit pulse is in the cycle the beat is popped, registered and asserted at the same edge as fsabo_valid.
- Throughput: 1 beat/cycle while credits are available. A burst never interleaves with another client.
- Reset values: fsabo_valid = 0, all fsabo_* fields = 0, cli_fsabo_credit = 0, cur_owner = 0.
- With FIFO_DEPTH = 4 and a continuous stream of beats, a client sustains full rate as long as its credit pulse loop completes in ≤ 4 cycles.

## Structure
- FSAB field widths, FSAB_READ/FSAB_WRITE and FSAB_INITIAL_CREDITS come from the shared fsab_defines.vh.
- Add FSAB_BEAT_W (packed beat width) to that header.
- One sub-module, **fsab_skid_fifo**:
  - Parameterized width and depth.
  - Ports: push, pop, full, empty, head.
  - Synchronous active-high reset; instantiated NCLIENTS times.
- Arbitration, burst lock and credit counter live in the top module.

## Test plan
- **Single read:** reset, client 0 sends a read (addr 0x1000, len 8) → fsabo_valid one cycle later with addr 0x1000, len 8; cli_fsabo_credit[0] pulses once; up_credits drops by 1.
- **Round-robin:** both clients push one read in the same cycle → client 0 is forwarded first, client 1 next cycle; cur_owner = 0 then 1.
- **Burst lock:** client 1 writes len 4 (4 beats); client 0 reads during beat 2 → the four write beats go out back-to-back, and client 0's read follows on the fifth cycle.
- **Credit stall:** UP_CREDITS = 2, three reads issued, no fsabo_credit → two beats forwarded and the third held. Pulse fsabo_credit → the third beat is forwarded the next cycle.
- **Simultaneous credit and forward:** fsabo_credit high in the same cycle as a forward → up_credits unchanged.
- **Reset mid-burst:** assert rst after beat 2 of a len-8 write → outputs 0, FIFOs empty, credits restored; a subsequent read goes out normally.
